delay_buffer_ctrl: RTL and testbench

//  Sequencing controller for a fixed-latency, free-running DELAY-stage delay buffer in an FFT stage.
//  - Tracks frames of FRAME_LEN samples on the input side.
//  - Produces the commutator select and sample index for each accepted input sample.
//  - Carries valid/sop/eop/sel through a sideband pipeline matched to the buffer latency.
//  - Flags framing errors and counts completed frames.

---
 rtl/delay_buffer_ctrl.sv | 135 +++++++++++++
 tb/tb_delay_buffer_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_buffer_ctrl.sv
// rtl/delay_buffer_ctrl.sv - frame sequencer and latency-matched sideband for an FFT delay buffer
module delay_buffer_ctrl #(
    parameter int DELAY     = 3,
    parameter int FRAME_LEN = 16,
    parameter int GROUP     = 4,
    parameter int CNT_W     = 4,
    parameter int SEL_W     = 2,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic [CNT_W-1:0]  in_idx,
    output logic              in_accept,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [SEL_W-1:0]  out_sel,
    output logic              frame_done,
    output logic              err_frame,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int FL_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int GRP_SH = $clog2(GROUP);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);
    localparam logic [FL_W-1:0]  FLUSH_INIT = FL_W'(DELAY - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic              err_q, err_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [DELAY-1:0]  vld_q, sop_q, eop_q;
    logic [SEL_W-1:0]  sel_q [DELAY];
    logic              sop_in, eop_in;
    logic [SEL_W-1:0]  sel_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        err_d     = 1'b0;
        in_accept = 1'b0;
        in_idx    = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        in_accept = 1'b1;
                        cnt_d     = CNT_W'(1);
                        state_d   = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                in_idx = in_sop ? '0 : cnt_q;
                if (in_valid) begin
                    in_accept = 1'b1;
                    // A premature sop abandons the open frame and restarts at index 0.
                    if (in_sop) begin
                        err_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        flush_d = FLUSH_INIT;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (in_valid && in_sop) begin
                    in_accept = 1'b1;
                    cnt_d     = CNT_W'(1);
                    state_d   = RUN;
                end else begin
                    err_d = in_valid;
                    if (flush_q == '0) state_d = IDLE;
                    else               flush_d = flush_q - FL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sop_in = in_accept && (in_idx == '0);
    assign eop_in = in_accept && (in_idx == LAST_IDX);
    assign sel_in = in_accept ? SEL_W'(in_idx >> GRP_SH) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            vld_q   <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
            for (int i = 0; i < DELAY; i++) sel_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            if (eop_q[DELAY-1]) fcnt_q <= fcnt_q + FCNT_W'(1);
            for (int i = DELAY - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                sop_q[i] <= sop_q[i-1];
                eop_q[i] <= eop_q[i-1];
                sel_q[i] <= sel_q[i-1];
            end
            vld_q[0] <= in_accept;
            sop_q[0] <= sop_in;
            eop_q[0] <= eop_in;
            sel_q[0] <= sel_in;
        end
    end

    assign out_valid  = vld_q[DELAY-1];
    assign out_sop    = sop_q[DELAY-1];
    assign out_eop    = eop_q[DELAY-1];
    assign out_sel    = sel_q[DELAY-1];
    assign frame_done = eop_q[DELAY-1];
    assign err_frame  = err_q;
    assign frame_cnt  = fcnt_q;
    assign busy       = (state_q != IDLE) || (|vld_q);
endmodule

// File: tb/tb_delay_buffer_ctrl.sv
// tb/tb_delay_buffer_ctrl.sv - directed and randomized bench for delay_buffer_ctrl
module tb_delay_buffer_ctrl;
    localparam int DELAY = 3, FRAME_LEN = 16, GROUP = 4, CNT_W = 4, SEL_W = 2, FCNT_W = 16;
    localparam int VW = 1 + CNT_W + 4 + SEL_W + 2 + FCNT_W;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sop = 1'b0;
    logic [CNT_W-1:0] in_idx;
    logic in_accept, out_valid, out_sop, out_eop, frame_done, err_frame, busy;
    logic [SEL_W-1:0] out_sel;
    logic [FCNT_W-1:0] frame_cnt;
    logic [VW-1:0] got;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    delay_buffer_ctrl #(.DELAY(DELAY), .FRAME_LEN(FRAME_LEN), .GROUP(GROUP),
                        .CNT_W(CNT_W), .SEL_W(SEL_W), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_idx(in_idx), .in_accept(in_accept), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_sel(out_sel),
        .frame_done(frame_done), .err_frame(err_frame), .busy(busy),
        .frame_cnt(frame_cnt));

    assign got = {in_accept, in_idx, out_valid, out_sop, out_eop, frame_done,
                  out_sel, err_frame, busy, frame_cnt};

    // Reference: a frame is "open" with a next index; accepted samples reappear DELAY cycles later.
    typedef struct packed {logic v; logic s; logic e; logic [SEL_W-1:0] sel;} sb_t;
    sb_t pipe[$];
    sb_t m_rec;
    bit m_active, m_acc, m_err;
    int m_nidx, m_idx;
    logic [FCNT_W-1:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_nidx = 0; m_err = 0; m_cnt = '0;
            pipe.delete();
            for (int i = 0; i < DELAY; i++) pipe.push_back('0);
        end else begin
            if (pipe[0].e) m_cnt = m_cnt + 1'b1;
            m_acc = in_valid && (in_sop || m_active);
            m_idx = (in_sop || !m_active) ? 0 : m_nidx;
            m_err = in_valid && (in_sop == m_active);
            m_rec = '0;
            if (m_acc) begin
                m_rec.v = 1'b1;
                m_rec.s = (m_idx == 0);
                m_rec.e = (m_idx == FRAME_LEN - 1);
                m_rec.sel = SEL_W'(m_idx / GROUP);
                m_active = (m_idx != FRAME_LEN - 1);
                m_nidx = m_idx + 1;
            end
            void'(pipe.pop_front());
            pipe.push_back(m_rec);
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        bit b;
        bit acc;
        int idx;
        b = m_active;
        foreach (pipe[i]) if (pipe[i].v) b = 1;
        acc = in_valid && (in_sop || m_active);
        idx = (in_sop || !m_active) ? 0 : m_nidx;
        return {acc, CNT_W'(idx), pipe[0].v, pipe[0].s, pipe[0].e, pipe[0].e,
                pipe[0].sel, m_err, b, m_cnt};
    endfunction

    task automatic drive(input bit v, input bit s);
        @(negedge clk);
        in_valid = v;
        in_sop = s;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", got); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL reset_release got=%h exp=0", got); end
    endtask

    task automatic test_single_frame();
        int sop_at, eop_at, nv, sel_bad;
        sop_at = -1; eop_at = -1; nv = 0; sel_bad = 0;
        do_reset();
        for (int k = 0; k < 16 + DELAY + 4; k++) begin
            drive(k < 16, k == 0);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL t1_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
            if (out_valid) begin
                if (out_sel !== SEL_W'(nv / GROUP)) sel_bad++;
                nv++;
            end
            if (out_sop) sop_at = k;
            if (out_eop) eop_at = k;
        end
        n_cmp++; if (sop_at != DELAY) begin n_bad++; $display("FAIL t1_sop_at got=%0d exp=%0d", sop_at, DELAY); end
        n_cmp++; if (eop_at != DELAY + 15) begin n_bad++; $display("FAIL t1_eop_at got=%0d exp=%0d", eop_at, DELAY + 15); end
        n_cmp++; if (nv != 16 || sel_bad != 0) begin n_bad++; $display("FAIL t1_sel_seq got=%0d/%0d exp=16/0", nv, sel_bad); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL t1_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_gaps();
        int eop_at, lows, nv, sel_bad;
        eop_at = -1; lows = 0; nv = 0; sel_bad = 0;
        do_reset();
        for (int k = 0; k < 18 + DELAY + 4; k++) begin
            drive(k < 18 && k != 2 && k != 10, k == 0);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL t2_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
            if (k >= DELAY && k <= DELAY + 17 && !out_valid) begin
                lows++;
                n_cmp++;
                if (k != DELAY + 2 && k != DELAY + 10) begin n_bad++; $display("FAIL t2_gap_pos got=%0d exp=%0d_or_%0d", k, DELAY + 2, DELAY + 10); end
            end
            if (out_valid) begin
                if (out_sel !== SEL_W'(nv / GROUP)) sel_bad++;
                nv++;
            end
            if (out_eop) eop_at = k;
        end
        n_cmp++; if (lows != 2) begin n_bad++; $display("FAIL t2_gap_count got=%0d exp=2", lows); end
        n_cmp++; if (eop_at != DELAY + 17) begin n_bad++; $display("FAIL t2_eop_at got=%0d exp=%0d", eop_at, DELAY + 17); end
        n_cmp++; if (nv != 16 || sel_bad != 0) begin n_bad++; $display("FAIL t2_sel_seq got=%0d/%0d exp=16/0", nv, sel_bad); end
    endtask

    task automatic test_back_to_back();
        int eops, first_eop, second_sop, idle_cnt;
        eops = 0; first_eop = -1; second_sop = -1; idle_cnt = 0;
        do_reset();
        for (int k = 0; k < 32 + DELAY + 4; k++) begin
            drive(k < 32, k == 0 || k == 16);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL t3_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
            if (out_eop) begin eops++; if (first_eop < 0) first_eop = k; end
            if (out_sop && k > DELAY) second_sop = k;
            if (k >= 1 && k <= 31 + DELAY && !busy) idle_cnt++;
        end
        n_cmp++; if (first_eop != DELAY + 15 || second_sop != DELAY + 16) begin
            n_bad++; $display("FAIL t3_seam got=%0d,%0d exp=%0d,%0d", first_eop, second_sop, DELAY + 15, DELAY + 16); end
        n_cmp++; if (idle_cnt != 0) begin n_bad++; $display("FAIL t3_no_idle got=%0d exp=0", idle_cnt); end
        n_cmp++; if (eops != 2 || frame_cnt !== 16'd2) begin n_bad++; $display("FAIL t3_frames got=%0d,%0d exp=2,2", eops, frame_cnt); end
    endtask

    task automatic test_sop_abort();
        int errs, err_at, eops, eop_at, sop2_at;
        errs = 0; err_at = -1; eops = 0; eop_at = -1; sop2_at = -1;
        do_reset();
        for (int k = 0; k < 21 + DELAY + 4; k++) begin
            drive(k < 21, k == 0 || k == 5);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL t4_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
            if (err_frame) begin errs++; err_at = k; end
            if (out_eop) begin eops++; eop_at = k; end
            if (out_sop && k > DELAY) sop2_at = k;
        end
        n_cmp++; if (errs != 1 || err_at != 6) begin n_bad++; $display("FAIL t4_err got=%0d@%0d exp=1@6", errs, err_at); end
        n_cmp++; if (sop2_at != 5 + DELAY) begin n_bad++; $display("FAIL t4_new_sop got=%0d exp=%0d", sop2_at, 5 + DELAY); end
        n_cmp++; if (eops != 1 || eop_at != 20 + DELAY) begin n_bad++; $display("FAIL t4_eop got=%0d@%0d exp=1@%0d", eops, eop_at, 20 + DELAY); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL t4_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_stray_valid();
        int errs, nv;
        errs = 0; nv = 0;
        do_reset();
        for (int k = 0; k < 18 + DELAY + 4; k++) begin
            drive(k == 0 || (k >= 2 && k <= 18), k == 2);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL t5_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
            if (k == 0 || k == 18) begin
                n_cmp++;
                if (in_accept !== 1'b0) begin n_bad++; $display("FAIL t5_accept k=%0d got=%b exp=0", k, in_accept); end
            end
            if (err_frame) begin
                errs++;
                n_cmp++;
                if (k != 1 && k != 19) begin n_bad++; $display("FAIL t5_err_pos got=%0d exp=1_or_19", k); end
            end
            if (out_valid) nv++;
        end
        n_cmp++; if (errs != 2) begin n_bad++; $display("FAIL t5_err_count got=%0d exp=2", errs); end
        n_cmp++; if (nv != 16 || busy !== 1'b0) begin n_bad++; $display("FAIL t5_outputs got=%0d,%b exp=16,0", nv, busy); end
    endtask

    task automatic test_reset_mid_frame();
        int eops;
        eops = 0;
        do_reset();
        for (int k = 0; k <= 8; k++) drive(1'b1, k == 0);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
        for (int r = 0; r < 3; r++) begin
            #1;
            n_cmp++;
            if (got !== '0) begin n_bad++; $display("FAIL t6_in_reset r=%0d got=%h exp=0", r, got); end
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16 + DELAY + 4; k++) begin
            drive(k < 16, k == 0);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL t6_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
            if (out_eop) eops++;
        end
        n_cmp++; if (eops != 1 || frame_cnt !== 16'd1) begin n_bad++; $display("FAIL t6_frames got=%0d,%0d exp=1,1", eops, frame_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 13) == 0);
            n_cmp++;
            if (got !== exp_vec()) begin n_bad++; $display("FAIL rand_vec k=%0d got=%h exp=%h", k, got, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_sop_abort();
        test_stray_valid();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
